// File: rtl/delaybuffer_pkg.sv
// Shared types and helpers for the programmable delay buffer.
package delaybuffer_pkg;

    // Controller states: CFG decides the post-config state, PRIME emits
    // zeros while the delay line fills, RUN emits delayed beats.
    typedef enum logic [1:0] {
        ST_CFG   = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    // Source of the output word latched with each accepted beat.
    typedef enum logic [1:0] {
        SEL_ZERO = 2'd0,
        SEL_RAM  = 2'd1,
        SEL_BYP  = 2'd2
    } out_sel_e;

    // Address width needed to index max_delay storage words (at least 1 bit).
    function automatic int ptr_width(input int max_delay);
        return (max_delay > 1) ? $clog2(max_delay) : 1;
    endfunction

endpackage

// File: rtl/delaybuffer_if.sv
// Configuration, input-stream and output-stream signals of the delay buffer.
// Handshake: a beat (or config word) transfers on a rising clock edge where
// valid and ready are both high; the source holds valid and payload stable
// while valid is high and ready is low.
interface delaybuffer_if #(
    parameter int width_p     = 16,
    parameter int channels_p  = 2,
    parameter int max_delay_p = 512
);
    localparam int DW = $clog2(max_delay_p + 1);

    logic [DW-1:0]                  cfg_delay_i;
    logic                           cfg_valid_i;
    logic                           cfg_ready_o;
    logic                           flush_i;
    logic [width_p*channels_p-1:0]  data_i;
    logic                           valid_i;
    logic                           ready_o;
    logic [width_p*channels_p-1:0]  data_o;
    logic                           valid_o;
    logic                           ready_i;
    logic [DW-1:0]                  delay_o;
    logic                           primed_o;

    modport master (
        output cfg_delay_i, cfg_valid_i, flush_i, data_i, valid_i, ready_i,
        input  cfg_ready_o, ready_o, data_o, valid_o, delay_o, primed_o
    );

    modport slave (
        input  cfg_delay_i, cfg_valid_i, flush_i, data_i, valid_i, ready_i,
        output cfg_ready_o, ready_o, data_o, valid_o, delay_o, primed_o
    );

endinterface

// File: rtl/ram_1r1w_sync.sv
// Simple dual-port RAM: one synchronous write port, one registered read port.
// A read and write of the same address in one cycle returns the old word.
module ram_1r1w_sync #(
    parameter int width_p  = 32,
    parameter int depth_p  = 512,
    parameter int addr_w_p = 9
) (
    input  logic                clk_i,
    input  logic                we_i,
    input  logic [addr_w_p-1:0] waddr_i,
    input  logic [width_p-1:0]  wdata_i,
    input  logic                re_i,
    input  logic [addr_w_p-1:0] raddr_i,
    output logic [width_p-1:0]  rdata_o
);

    logic [width_p-1:0] mem_q [depth_p];
    logic [width_p-1:0] rdata_q;

    // Write and registered read; read data holds when re_i is low.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/delaybuffer_prog.sv
// Programmable delay line: each accepted beat releases the beat accepted D
// beats earlier (zeros until D beats have been seen), one cycle later.
module delaybuffer_prog
    import delaybuffer_pkg::*;
#(
    parameter int width_p     = 16,
    parameter int channels_p  = 2,
    parameter int max_delay_p = 512
) (
    input  logic          clk_i,
    input  logic          reset_ni,
    delaybuffer_if.slave  bus,
    output state_e        dbg_state_o
);

    localparam int W  = width_p * channels_p;
    localparam int DW = $clog2(max_delay_p + 1);
    localparam int PW = ptr_width(max_delay_p);
    localparam logic [DW-1:0] MAX_D = DW'(max_delay_p);

    state_e        state_q, state_d, state_cur;
    logic [DW-1:0] delay_q, delay_d, delay_eff, cfg_clamped;
    logic [DW-1:0] fill_q, fill_d, fill_eff;
    logic [PW-1:0] ptr_q, ptr_d, ptr_eff;
    logic          valid_q, valid_d;
    out_sel_e      sel_q, sel_d;
    logic [W-1:0]  byp_q, byp_d;
    logic [W-1:0]  ram_rdata;
    logic [W-1:0]  data_out;
    logic          primed;
    logic          ready, cfg_acc, in_acc, restart, ram_en;

    assign ready       = !valid_q | bus.ready_i;
    assign cfg_acc     = bus.cfg_valid_i & !valid_q;
    assign in_acc      = bus.valid_i & ready;
    assign cfg_clamped = (bus.cfg_delay_i > MAX_D) ? MAX_D : bus.cfg_delay_i;

    // A config or flush restarts the line before a same-cycle beat is counted.
    assign restart   = cfg_acc | bus.flush_i;
    assign delay_eff = cfg_acc ? cfg_clamped : delay_q;
    assign fill_eff  = restart ? '0 : fill_q;
    assign ptr_eff   = restart ? '0 : ptr_q;
    assign ram_en    = in_acc & (delay_eff != '0);
    assign state_cur = cfg_acc ? ST_CFG : state_q;

    ram_1r1w_sync #(
        .width_p  (W),
        .depth_p  (max_delay_p),
        .addr_w_p (PW)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (ram_en),
        .waddr_i (ptr_eff),
        .wdata_i (bus.data_i),
        .re_i    (ram_en),
        .raddr_i (ptr_eff),
        .rdata_o (ram_rdata)
    );

    // FSM state register.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= ST_PRIME;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: RUN once the fill count has reached the delay in effect.
    always_comb begin
        state_d = state_q;
        case (state_cur)
            ST_CFG:   state_d = (fill_d >= delay_eff) ? ST_RUN : ST_PRIME;
            ST_PRIME: state_d = (fill_d >= delay_eff) ? ST_RUN : ST_PRIME;
            ST_RUN:   state_d = (bus.flush_i && (fill_d < delay_eff)) ? ST_PRIME : ST_RUN;
            default:  state_d = ST_PRIME;
        endcase
    end

    // FSM outputs: primed flag and output word selection.
    always_comb begin
        primed = (state_q == ST_RUN);
        case (sel_q)
            SEL_RAM: data_out = ram_rdata;
            SEL_BYP: data_out = byp_q;
            default: data_out = '0;
        endcase
    end

    // Datapath next state: pointer, fill count, output register and select.
    always_comb begin
        delay_d = delay_eff;
        fill_d  = fill_eff;
        ptr_d   = ptr_eff;
        valid_d = valid_q;
        sel_d   = sel_q;
        byp_d   = byp_q;
        if (in_acc) begin
            valid_d = 1'b1;
            if (delay_eff == '0) begin
                sel_d = SEL_BYP;
                byp_d = bus.data_i;
            end else begin
                sel_d = (fill_eff < delay_eff) ? SEL_ZERO : SEL_RAM;
                if (fill_eff < delay_eff) begin
                    fill_d = fill_eff + DW'(1);
                end
                ptr_d = (DW'(ptr_eff) == delay_eff - DW'(1)) ? '0 : ptr_eff + PW'(1);
            end
        end else if (bus.ready_i) begin
            valid_d = 1'b0;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            delay_q <= MAX_D;
            fill_q  <= '0;
            ptr_q   <= '0;
            valid_q <= 1'b0;
            sel_q   <= SEL_ZERO;
            byp_q   <= '0;
        end else begin
            delay_q <= delay_d;
            fill_q  <= fill_d;
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            sel_q   <= sel_d;
            byp_q   <= byp_d;
        end
    end

    assign bus.ready_o     = ready;
    assign bus.cfg_ready_o = !valid_q;
    assign bus.valid_o     = valid_q;
    assign bus.data_o      = data_out;
    assign bus.delay_o     = delay_q;
    assign bus.primed_o    = primed;
    assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_delaybuffer_prog.sv
module tb_delaybuffer_prog;
    import delaybuffer_pkg::*;

    localparam int WIDTH = 16;
    localparam int CH    = 2;
    localparam int MAXD  = 512;
    localparam int W     = WIDTH * CH;
    localparam int DW    = $clog2(MAXD + 1);

    // ---------------- clock / reset ----------------
    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    state_e dbg_state;

    always #5 clk = ~clk;

    delaybuffer_if #(.width_p(WIDTH), .channels_p(CH), .max_delay_p(MAXD)) dif();

    delaybuffer_prog #(.width_p(WIDTH), .channels_p(CH), .max_delay_p(MAXD)) dut (
        .clk_i       (clk),
        .reset_ni    (rst_n),
        .bus         (dif),
        .dbg_state_o (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int          checks = 0;
    int          failures = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] line_q[$];   // reference delay line: D entries, oldest first
    int          model_d;
    int          model_fill;
    logic        prev_acc;
    logic        cfg_taken;
    int          accepted;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: a restart refills the line with D zeros.
    task automatic model_restart();
        line_q.delete();
        for (int i = 0; i < model_d; i++) line_q.push_back('0);
        model_fill = 0;
    endtask

    // ---------------- driver ----------------
    // One clock cycle of stimulus; acceptance is resolved at the negedge and
    // the reference model updated in transfer order (config/flush first).
    task automatic cycle(input logic v, input logic [W-1:0] d, input logic rdy,
                         input logic cv, input int cd, input logic fl);
        logic in_a, cfg_a;
        @(posedge clk); #1;
        dif.valid_i     = v;
        dif.data_i      = d;
        dif.ready_i     = rdy;
        dif.cfg_valid_i = cv;
        dif.cfg_delay_i = DW'(cd);
        dif.flush_i     = fl;
        @(negedge clk);
        check("primed", W'(dif.primed_o), W'(model_fill >= model_d));
        check("delay", W'(dif.delay_o), W'(model_d));
        if (prev_acc) check("latency_valid", W'(dif.valid_o), W'(1));
        cfg_a = cv && dif.cfg_ready_o;
        in_a  = v && dif.ready_o;
        cfg_taken = cfg_a;
        if (cfg_a) begin
            model_d = (cd > MAXD) ? MAXD : cd;
            model_restart();
        end else if (fl) begin
            model_restart();
        end
        if (in_a) begin
            line_q.push_back(d);
            exp_q.push_back(line_q.pop_front());
            model_fill++;
            accepted++;
        end
        prev_acc = in_a;
    endtask

    task automatic drain();
        repeat (4) cycle(1'b0, '0, 1'b1, 1'b0, 0, 1'b0);
    endtask

    task automatic do_config(input int d, input logic v, input logic [W-1:0] data);
        drain();
        for (int i = 0; i < 8; i++) begin
            cycle(v, data, 1'b1, 1'b1, d, 1'b0);
            if (cfg_taken) break;
        end
        check("cfg_accept", W'(cfg_taken), W'(1));
    endtask

    // ---------------- monitor ----------------
    logic         held_v = 1'b0;
    logic [W-1:0] held_d;

    always @(negedge clk) begin
        logic [W-1:0] e;
        if (!rst_n) begin
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                check("stall_valid", W'(dif.valid_o), W'(1));
                if (dif.valid_o) check("stall_data", dif.data_o, held_d);
            end
            held_v = 1'b0;
            if (dif.valid_o) begin
                if (dif.ready_i) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_output", W'(1), W'(0));
                    end else begin
                        e = exp_q.pop_front();
                        check("data", dif.data_o, e);
                    end
                end else begin
                    held_v = 1'b1;
                    held_d = dif.data_o;
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int cyc;
        dif.valid_i = 0; dif.data_i = '0; dif.ready_i = 0;
        dif.cfg_valid_i = 0; dif.cfg_delay_i = '0; dif.flush_i = 0;
        model_d = MAXD; model_restart(); prev_acc = 0; accepted = 0; cfg_taken = 0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", W'(dif.valid_o), W'(0));
        check("rst_data", dif.data_o, W'(0));
        check("rst_primed", W'(dif.primed_o), W'(0));
        check("rst_delay", W'(dif.delay_o), W'(MAXD));
        check("rst_state", W'(dbg_state), W'(ST_PRIME));
        @(negedge clk);
        rst_n = 1'b1;

        // D=4, stream 1..10
        do_config(4, 1'b0, '0);
        for (int i = 1; i <= 10; i++) cycle(1'b1, W'(i), 1'b1, 1'b0, 0, 1'b0);
        drain();

        // D=0 bypass, stream 7,8,9
        do_config(0, 1'b0, '0);
        for (int i = 7; i <= 9; i++) cycle(1'b1, W'(i), 1'b1, 1'b0, 0, 1'b0);
        drain();

        // D=3 with a beat in the config cycle, then random valid/ready
        do_config(3, 1'b1, W'($urandom));
        cyc = 0;
        while (accepted < 1200 && cyc < 12000) begin
            cycle(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)), 1'b0, 0, 1'b0);
            cyc++;
        end
        check("random_progress", W'(accepted >= 1200), W'(1));
        // flush together with an accepted beat
        cycle(1'b1, W'($urandom), 1'b1, 1'b0, 0, 1'b1);
        for (int i = 0; i < 6; i++) cycle(1'b1, W'($urandom), 1'b1, 1'b0, 0, 1'b0);
        drain();

        // D=5, flush after 8 beats
        do_config(5, 1'b0, '0);
        for (int i = 1; i <= 8; i++) cycle(1'b1, W'(100 + i), 1'b1, 1'b0, 0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0, 0, 1'b1);
        for (int i = 9; i <= 20; i++) cycle(1'b1, W'(100 + i), 1'b1, 1'b0, 0, 1'b0);
        drain();

        // Oversized delay request clamps to MAXD
        do_config(1000, 1'b0, '0);
        for (int i = 0; i < MAXD + 8; i++) cycle(1'b1, W'($urandom), 1'b1, 1'b0, 0, 1'b0);
        drain();

        // Reset mid-stream at D=4 while an output is stalled
        do_config(4, 1'b0, '0);
        for (int i = 1; i <= 6; i++) cycle(1'b1, W'(200 + i), 1'b1, 1'b0, 0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0, 0, 1'b0);
        #2;
        rst_n = 1'b0;
        dif.valid_i = 0;
        #1;
        check("midrst_valid", W'(dif.valid_o), W'(0));
        check("midrst_data", dif.data_o, W'(0));
        check("midrst_primed", W'(dif.primed_o), W'(0));
        check("midrst_delay", W'(dif.delay_o), W'(MAXD));
        exp_q.delete();
        model_d = MAXD; model_restart(); prev_acc = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < MAXD + 8; i++) cycle(1'b1, W'($urandom), 1'b1, 1'b0, 0, 1'b0);
        drain();

        check("drain_empty", W'(exp_q.size()), W'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
